// File: rtl/btn_conditioner.sv
// btn_conditioner
//
// Multi-channel push-button conditioner. Each raw button is passed through a
// two-flop synchronizer and then debounced by a per-channel four-state FSM with
// a stability counter. Each channel produces a clean level and a one-cycle
// press pulse. It can also produce a one-cycle release pulse.
//
// Optional feature: define BTN_COND_RELEASE_EN to build the btn_release port
// and its pulse flops. When the macro is undefined, the port and flops are
// absent and all other behaviour is unchanged.
//
// Parameters
//   N         : number of button channels (1..8)
//   DB_CYCLES : cycles the synchronized input must stay stable (2..2^24-1)
//
// Ports
//   clk         : system clock
//   reset       : asynchronous, active-high reset
//   btn_raw     : raw bouncy button inputs, bit i is channel i
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on each accepted 0->1 transition
//   btn_release : one-cycle pulse on each accepted 1->0 transition (optional)

module btn_conditioner #(
    parameter int unsigned N         = 2,
    parameter int unsigned DB_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press
`ifdef BTN_COND_RELEASE_EN
    ,
    output logic [N-1:0] btn_release
`endif
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    // Two-flop synchronizer. The FSMs only ever look at s2_q.
    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            press_q, press_d;
`ifdef BTN_COND_RELEASE_EN
        logic            release_q, release_d;
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
`ifdef BTN_COND_RELEASE_EN
            release_d = 1'b0;
`endif
            unique case (state_q)
                StLow: begin
                    if (s2_q[i]) begin
                        state_d = StWaitHigh;
                        cnt_d   = '0;
                    end
                end
                StWaitHigh: begin
                    if (!s2_q[i]) begin
                        // Glitch: back to LOW with no pulse.
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StHigh: begin
                    if (!s2_q[i]) begin
                        state_d = StWaitLow;
                        cnt_d   = '0;
                    end
                end
                StWaitLow: begin
                    if (s2_q[i]) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StLow;
                        cnt_d   = '0;
`ifdef BTN_COND_RELEASE_EN
                        release_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StLow;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StLow;
                cnt_q   <= '0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
            end
        end

`ifdef BTN_COND_RELEASE_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                release_q <= 1'b0;
            end else begin
                release_q <= release_d;
            end
        end

        assign btn_release[i] = release_q;
`endif

        // The level has already been accepted once the FSM leaves WAIT_HIGH.
        // It holds until a release is accepted.
        assign btn_level[i] = (state_q == StHigh) || (state_q == StWaitLow);
        assign btn_press[i] = press_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//
// Bench for btn_conditioner with N=2, DB_CYCLES=4. A run-length reference
// model predicts level, press and release on every cycle. Directed sections
// pin exact pulse timing with literal values. A randomized section then mixes
// long holds, short bounces and occasional resets.

module tb_btn_conditioner;

    localparam int unsigned N  = 2;
    localparam int unsigned DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
`ifdef BTN_COND_RELEASE_EN
    logic [N-1:0] btn_release;
`endif

    btn_conditioner #(
        .N         (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press)
`ifdef BTN_COND_RELEASE_EN
        ,
        .btn_release (btn_release)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model. The FSM sees the raw value sampled two edges earlier.
    // A channel's level flips on the edge where the run of consecutive samples
    // disagreeing with the level reaches DB+1. A pulse is emitted on that edge.
    logic [N-1:0] d1, d2;
    logic [N-1:0] m_lvl, m_press, m_rel;
    int           run [N];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 = '0;
            d2 = '0;
            m_lvl = '0;
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
                if (d2[i] != m_lvl[i]) run[i] = run[i] + 1;
                else run[i] = 0;
                if (run[i] == DB + 1) begin
                    if (m_lvl[i]) m_rel[i] = 1'b1;
                    else m_press[i] = 1'b1;
                    m_lvl[i] = ~m_lvl[i];
                    run[i] = 0;
                end
            end
            d2 = d1;
            d1 = btn_raw;
        end
    end

    bit check_en = 1'b0;

    // This process compares the DUT outputs against the model on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("model_level", 32'(btn_level), 32'(m_lvl));
                check("model_press", 32'(btn_press), 32'(m_press));
`ifdef BTN_COND_RELEASE_EN
                check("model_release", 32'(btn_release), 32'(m_rel));
`endif
            end
        end
    end

    // Inputs change shortly after the falling edge. This keeps them away from
    // both the compare point and the sampling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Set btn_raw and step k cycles; literal press expected only at step 7.
    task automatic press_window(input string name, input logic [N-1:0] raw,
                                input logic [N-1:0] exp_press);
        btn_raw = raw;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check(name, 32'(btn_press), (k == 7) ? 32'(exp_press) : 32'd0);
        end
    endtask

    int hold [N];

    initial begin
        // Reset held with both buttons pressed: all outputs stay low.
        reset = 1'b1;
        btn_raw = 2'b11;
        step(1);
        check_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("rst_level", 32'(btn_level), 32'd0);
            check("rst_press", 32'(btn_press), 32'd0);
`ifdef BTN_COND_RELEASE_EN
            check("rst_release", 32'(btn_release), 32'd0);
`endif
        end
        // After release, the held buttons are accepted as a fresh press.
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("rst_exit_press", 32'(btn_press), (k == 7) ? 32'h3 : 32'h0);
            check("rst_exit_level", 32'(btn_level), (k >= 7) ? 32'h3 : 32'h0);
        end

        // Release both buttons. Each level drops 6 edges later.
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("release_level", 32'(btn_level), (k >= 7) ? 32'h0 : 32'h3);
`ifdef BTN_COND_RELEASE_EN
            check("release_pulse", 32'(btn_release), (k == 7) ? 32'h3 : 32'h0);
`endif
        end
        step(4);

        // Clean press on channel 0.
        press_window("clean_press", 2'b01, 2'b01);
        check("clean_level", 32'(btn_level), 32'h1);
        btn_raw = 2'b00;
        step(12);

        // Bounce 1,0,1,0 at 2-cycle spacing, then hold 1.
        for (int b = 0; b < 4; b++) begin
            btn_raw = (b % 2 == 0) ? 2'b01 : 2'b00;
            step(1);
            check("bounce_quiet", 32'(btn_press), 32'h0);
            step(1);
            check("bounce_quiet", 32'(btn_press), 32'h0);
        end
        press_window("bounce_press", 2'b01, 2'b01);
        btn_raw = 2'b00;
        step(12);

        // Simultaneous press on both channels.
        press_window("simul_press", 2'b11, 2'b11);
        btn_raw = 2'b00;
        step(12);

        // Reset while channel 1 is in WAIT_HIGH with count 2. This is 5 steps
        // after the raw input rises.
        btn_raw = 2'b10;
        step(5);
        check("mid_pre_level", 32'(btn_level), 32'h0);
        reset = 1'b1;
        btn_raw = 2'b00;
        #1;
        check("mid_rst_level", 32'(btn_level), 32'h0);
        check("mid_rst_press", 32'(btn_press), 32'h0);
        step(2);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check("mid_no_press", 32'(btn_press), 32'h0);
        end

        // Randomized holds and bounces, with a reset now and then.
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(1, 14));
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel push-button conditioner that sits directly upstream of the reaction timer FSM and feeds its start and stop inputs. Each raw board button is synchronized into the clk domain and debounced by a per-channel four-state FSM with a stability counter. Each channel produces a clean level and a single-cycle press pulse, and optionally a release pulse. The timer therefore sees exactly one event per physical press.

## Interface
- N, default 2: number of button channels (1..8).
- DB_CYCLES, default 2000000: cycles the synchronized input must stay stable before a change is accepted (20 ms at 100 MHz); legal range 2..2^24-1.
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- btn_raw, input, N: raw, bouncy, asynchronous button inputs; bit i is channel i.
- btn_level, output, N: debounced level per channel.
- btn_press, output, N: one-cycle pulse on each accepted 0→1 transition.
- btn_release, output, N: one-cycle pulse on each accepted 1→0 transition; present only with BTN_COND_RELEASE_EN.

## Operation
- Synchronizer: two flops per channel (s1, s2); the FSM sees only s2.
- Counter width: ceil(log2(DB_CYCLES)) bits per channel; no wrap is possible because the counter clears before reaching DB_CYCLES.
- Per-channel states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
- LOW:
  - s2=1 → WAIT_HIGH, counter cleared to 0.
  - Otherwise stay in LOW.
- WAIT_HIGH:
  - s2=0 → LOW, counter cleared; the glitch is rejected and no pulse is issued.
  - s2=1 and count==DB_CYCLES-1 → HIGH; btn_press[i]=1 for one cycle.
  - Otherwise counter increments.
- HIGH:
  - s2=0 → WAIT_LOW, counter cleared.
- WAIT_LOW:
  - Mirror of WAIT_HIGH.
  - s2=1 → HIGH with no pulse.
  - s2=0 and count==DB_CYCLES-1 → LOW; btn_release[i]=1 if compiled in.
- btn_level[i] is 1 in HIGH and WAIT_LOW, and 0 in LOW and WAIT_HIGH.
- Channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle; there is no arbitration, and priority belongs to the consumer.
- A raw input that toggles faster than DB_CYCLES never changes btn_level and never pulses.

## Timing
- Reset values: all outputs 0, all states LOW, counters 0, synchronizer flops 0.
- Reset asserted mid-operation (including mid-WAIT_HIGH) returns a channel to LOW immediately and drops any pending pulse.
- A button held through reset release is accepted as a fresh press, DB_CYCLES+2 edges after reset deasserts.
- Latency: let edge 0 be the first clock edge that samples btn_raw[i]=1, with the input stable afterwards. Then:
  - s2=1 after edge 1.
  - WAIT_HIGH is entered at edge 2.
  - btn_press[i] and btn_level[i] go high after edge DB_CYCLES+2.
- Release latency is identical, measured from the first edge that samples btn_raw[i]=0.
- Pulses are registered outputs, high for exactly one cycle.
- A new press pulse needs a complete accepted release in between, so the minimum press-to-press spacing is 2·(DB_CYCLES+1) cycles.

## Configuration
- Macro: BTN_COND_RELEASE_EN.
- When defined:
  - The btn_release port exists.
  - The WAIT_LOW→LOW transition drives btn_release[i] high for one cycle.
- When undefined:
  - The port is absent and its flops are not built.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use N=2 and DB_CYCLES=4.
- Reset: hold reset with btn_raw=2'b11 → btn_level, btn_press and btn_release are all 0 throughout; release reset → btn_press=2'b11 for one cycle, 6 edges after reset deasserts.
- Clean press: btn_raw[0] rises and holds → btn_press[0] pulses exactly once, after edge 6 relative to the first sampling edge; btn_level[0]=1 from the same cycle.
- Bounce rejection: btn_raw[0] toggles 1,0,1,0,1 at 2-cycle spacing, then holds 1 → exactly one btn_press[0], timed 6 edges after the final 0→1 sample.
- Release: from HIGH, btn_raw[0] drops and holds → btn_level[0]=0 after 6 edges; with the macro, btn_release[0] pulses once; without it, no release port exists.
- Simultaneous press: both raw bits rise on the same edge → btn_press=2'b11 in the same single cycle.
- Reset mid-debounce: assert reset while channel 1 is in WAIT_HIGH with count 2 → no btn_press[1] ever appears for that press; outputs are 0 immediately.
